// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parametrised multi-stage pipeline register carrying a control
//             bundle and a data payload (EX -> MEM -> WB). Each stage has a
//             valid bit. The block supports a global stall, a per-stage flush
//             mask, forced-zero control on bubbles and registered occupancy.
//  Options  : PIPE_PERF_CNT_EN - enables the saturating Stall_Cycles and
//             Flush_Events performance counters. When it is undefined, both
//             counters are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 32,
  parameter int STAGES = 1
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic                         In_Valid,
  input  logic [CTRL_W-1:0]            In_Ctrl,
  input  logic [DATA_W-1:0]            In_Data,
  input  logic                         Stall,
  input  logic [STAGES-1:0]            Flush,
  output logic                         Out_Valid,
  output logic [CTRL_W-1:0]            Out_Ctrl,
  output logic [DATA_W-1:0]            Out_Data,
  output logic [$clog2(STAGES+1)-1:0]  Occupancy,
  output logic [15:0]                  Stall_Cycles,
  output logic [15:0]                  Flush_Events
);

  localparam int OCC_W = $clog2(STAGES+1);

  // Stage registers and their next-state values
  logic [STAGES-1:0] valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Values landing in each stage after the advance/hold choice, before flush
  logic [STAGES-1:0] pre_valid;
  logic [CTRL_W-1:0] pre_ctrl [STAGES];
  logic [DATA_W-1:0] pre_data [STAGES];

  // Select advance or hold for every stage. Incoming control is masked by
  // In_Valid so a bubble never carries an enable downstream.
  always_comb begin
    pre_valid = '0;
    for (int k = 0; k < STAGES; k++) begin
      pre_ctrl[k] = '0;
      pre_data[k] = '0;
    end
    if (Stall) begin
      pre_valid = valid_q;
      for (int k = 0; k < STAGES; k++) begin
        pre_ctrl[k] = ctrl_q[k];
        pre_data[k] = data_q[k];
      end
    end else begin
      pre_valid[0] = In_Valid;
      pre_ctrl[0]  = In_Valid ? In_Ctrl : '0;
      pre_data[0]  = In_Data;
      for (int k = 1; k < STAGES; k++) begin
        pre_valid[k] = valid_q[k-1];
        pre_ctrl[k]  = ctrl_q[k-1];
        pre_data[k]  = data_q[k-1];
      end
    end
  end

  // Apply the flush mask on top of the advance/hold result. Data is kept so
  // that a killed slot still shows the payload it would have carried.
  always_comb begin
    valid_d = pre_valid & ~Flush;
    for (int k = 0; k < STAGES; k++) begin
      ctrl_d[k] = Flush[k] ? '0 : pre_ctrl[k];
      data_d[k] = pre_data[k];
    end
  end

  // Occupancy is the population count of the valid bits being written, so
  // the registered count always matches the registered stage contents.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  // Stage state and occupancy registers; CLR takes priority over everything
  always_ff @(posedge CLK) begin
    if (CLR) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign Out_Valid = valid_q[STAGES-1];
  assign Out_Ctrl  = ctrl_q[STAGES-1];
  assign Out_Data  = data_q[STAGES-1];
  assign Occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        flush_hit;

  // Count stalled edges and edges where a flush destroys a live entry,
  // saturating at all-ones.
  always_comb begin
    flush_hit   = |(pre_valid & Flush);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_hit && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge CLK) begin
    if (CLR) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cycles = stall_cnt_q;
  assign Flush_Events = flush_cnt_q;
`else
  assign Stall_Cycles = 16'h0000;
  assign Flush_Events = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Directed self-checking bench for pipe_stage_reg with STAGES=3.
//             Counter expectations depend on PIPE_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int CTRL_W = 5;
  localparam int DATA_W = 32;
  localparam int STAGES = 3;

  logic              clk;
  logic              clr;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic [STAGES-1:0] flush;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cycles;
  logic [15:0]       flush_events;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .STAGES(STAGES)
  ) dut (
    .CLK         (clk),
    .CLR         (clr),
    .In_Valid    (in_valid),
    .In_Ctrl     (in_ctrl),
    .In_Data     (in_data),
    .Stall       (stall),
    .Flush       (flush),
    .Out_Valid   (out_valid),
    .Out_Ctrl    (out_ctrl),
    .Out_Data    (out_data),
    .Occupancy   (occupancy),
    .Stall_Cycles(stall_cycles),
    .Flush_Events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic test_reset();
    clr = 1'b1; stall = 1'b0; flush = '0;
    drive(1'b1, 5'h1F, 32'hDEADBEEF);
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_ctrl !== 5'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", out_ctrl); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (stall_cycles !== 16'h0 || flush_events !== 16'h0) begin
      errors++; $display("FAIL reset_counters got %h/%h exp 0/0", stall_cycles, flush_events); end
    clr = 1'b0;
  endtask

  // A,B,C,D,E pushed back to back; A exits on the 3rd edge.
  task automatic test_latency();
    drive(1'b1, 5'h11, 32'h1); step();
    checks++; if (occupancy !== 2'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_e1 occ %0d valid %0b exp 1/0", occupancy, out_valid); end
    drive(1'b1, 5'h12, 32'h2); step();
    checks++; if (occupancy !== 2'd2 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_e2 occ %0d valid %0b exp 2/0", occupancy, out_valid); end
    drive(1'b1, 5'h13, 32'h3); step();
    checks++; if (occupancy !== 2'd3 || out_valid !== 1'b1 || out_ctrl !== 5'h11 || out_data !== 32'h1) begin
      errors++; $display("FAIL lat_A occ %0d v %0b c %h d %h exp 3/1/11/1", occupancy, out_valid, out_ctrl, out_data); end
    drive(1'b1, 5'h14, 32'h4); step();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 5'h12 || out_data !== 32'h2) begin
      errors++; $display("FAIL lat_B v %0b c %h d %h exp 1/12/2", out_valid, out_ctrl, out_data); end
    drive(1'b1, 5'h15, 32'h5); step();
    checks++; if (occupancy !== 2'd3 || out_valid !== 1'b1 || out_ctrl !== 5'h13 || out_data !== 32'h3) begin
      errors++; $display("FAIL lat_C occ %0d v %0b c %h d %h exp 3/1/13/3", occupancy, out_valid, out_ctrl, out_data); end
  endtask

  // Pipe full (E,D,C); stall 4 edges with garbage inputs.
  task automatic test_stall();
    stall = 1'b1;
    drive(1'b1, 5'h1F, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (occupancy !== 2'd3 || out_valid !== 1'b1 || out_ctrl !== 5'h13 || out_data !== 32'h3) begin
        errors++; $display("FAIL stall_hold%0d occ %0d v %0b c %h d %h exp 3/1/13/3", i, occupancy, out_valid, out_ctrl, out_data); end
    end
    checks++; if (stall_cycles !== (PERF ? 16'd4 : 16'd0)) begin
      errors++; $display("FAIL stall_count got %0d exp %0d", stall_cycles, PERF ? 4 : 0); end
  endtask

  // Kill stage1 (D) while stalled, then drain to see D dead and E alive.
  task automatic test_flush_stall();
    stall = 1'b1; flush = 3'b010;
    step();
    checks++; if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_ctrl !== 5'h13 || out_data !== 32'h3) begin
      errors++; $display("FAIL fs_hold occ %0d v %0b c %h d %h exp 2/1/13/3", occupancy, out_valid, out_ctrl, out_data); end
    checks++; if (flush_events !== (PERF ? 16'd1 : 16'd0) || stall_cycles !== (PERF ? 16'd5 : 16'd0)) begin
      errors++; $display("FAIL fs_counters got %0d/%0d exp %0d/%0d", flush_events, stall_cycles, PERF ? 1 : 0, PERF ? 5 : 0); end
    stall = 1'b0; flush = '0;
    drive(1'b0, 5'h1F, 32'h77); step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 5'h00 || out_data !== 32'h4 || occupancy !== 2'd1) begin
      errors++; $display("FAIL fs_killed v %0b c %h d %h occ %0d exp 0/00/4/1", out_valid, out_ctrl, out_data, occupancy); end
    drive(1'b0, 5'h1F, 32'h88); step();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 5'h15 || out_data !== 32'h5 || occupancy !== 2'd1) begin
      errors++; $display("FAIL fs_E v %0b c %h d %h occ %0d exp 1/15/5/1", out_valid, out_ctrl, out_data, occupancy); end
  endtask

  // The bubble injected with ctrl 1F must exit with ctrl forced to 0.
  task automatic test_bubble();
    drive(1'b0, 5'h1F, 32'h99); step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 5'h00 || out_data !== 32'h77 || occupancy !== 2'd0) begin
      errors++; $display("FAIL bubble v %0b c %h d %h occ %0d exp 0/00/77/0", out_valid, out_ctrl, out_data, occupancy); end
  endtask

  // Pipe: G, bubble99, bubble88; flush all while advancing a valid entry.
  task automatic test_full_flush();
    drive(1'b1, 5'h16, 32'h6); step();
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL ff_fill occ %0d exp 1", occupancy); end
    flush = 3'b111;
    drive(1'b1, 5'h1F, 32'hAA); step();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 5'h00 || out_data !== 32'h99) begin
      errors++; $display("FAIL ff_all occ %0d v %0b c %h d %h exp 0/0/00/99", occupancy, out_valid, out_ctrl, out_data); end
    checks++; if (flush_events !== (PERF ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL ff_count got %0d exp %0d", flush_events, PERF ? 2 : 0); end
    flush = '0;
  endtask

  // Refill, then CLR in the middle of a stall+flush cycle.
  task automatic test_clr_mid();
    drive(1'b1, 5'h01, 32'h10); step();
    drive(1'b1, 5'h02, 32'h20); step();
    drive(1'b1, 5'h03, 32'h30); step();
    checks++; if (occupancy !== 2'd3 || out_ctrl !== 5'h01 || out_data !== 32'h10) begin
      errors++; $display("FAIL clr_fill occ %0d c %h d %h exp 3/01/10", occupancy, out_ctrl, out_data); end
    clr = 1'b1; stall = 1'b1; flush = 3'b001;
    step();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 5'h00 || out_data !== 32'h0) begin
      errors++; $display("FAIL clr_mid occ %0d v %0b c %h d %h exp all 0", occupancy, out_valid, out_ctrl, out_data); end
    checks++; if (stall_cycles !== 16'h0 || flush_events !== 16'h0) begin
      errors++; $display("FAIL clr_counters got %h/%h exp 0/0", stall_cycles, flush_events); end
    clr = 1'b0; stall = 1'b0; flush = '0;
    drive(1'b1, 5'h04, 32'h40); step();
    checks++; if (occupancy !== 2'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_after occ %0d v %0b exp 1/0", occupancy, out_valid); end
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; flush = '0;
    drive(1'b0, 5'h00, 32'h0);
    test_reset();
    test_latency();
    test_stall();
    test_flush_stall();
    test_bubble();
    test_full_flush();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, multi-stage pipeline register carrying a control bundle and a data word between execute, memory and writeback.
- Generalises the single-stage control latch. Adds:
  - configurable width and depth
  - a per-stage valid bit
  - global stall
  - per-stage flush mask
  - forced-zero control on bubbles
  - occupancy tracking
- STAGES=1 serves as the EX/MEM boundary; larger values model deeper memory paths.

Parameters:
- CTRL_W, 5, width of control bundle (e.g. Size, Enable, rw, Load, rf).
- DATA_W, 32, width of data/address payload.
- STAGES, 1, number of register stages; legal range 1..8.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- CLR  input  1  synchronous, active-high reset.
- In_Valid  input  1  entry at stage-0 input is a real instruction.
- In_Ctrl  input  CTRL_W  control bundle entering stage 0.
- In_Data  input  DATA_W  payload entering stage 0.
- Stall  input  1  hold all stages this cycle.
- Flush  input  STAGES  bit k kills the entry written into stage k this cycle.
- Out_Valid  output  1  valid of final stage.
- Out_Ctrl  output  CTRL_W  control of final stage.
- Out_Data  output  DATA_W  payload of final stage.
- Occupancy  output  $clog2(STAGES+1)  count of valid stages.
- Stall_Cycles  output  16  performance counter (see Optional Feature).
- Flush_Events  output  16  performance counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock CLK; reset CLR is synchronous and active-high. CLR has top priority.
- Reset: on CLR, every stage's valid, ctrl and data go to 0. Consequently Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0 and both counters=0 in the following cycle. CLR mid-stall or mid-flush behaves identically.
- Latency: an entry accepted with Stall=0 appears on the outputs exactly STAGES unstalled edges later.
- Advance (Stall=0):
  - stage0 <= {In_Valid, In_Ctrl, In_Data}
  - stage k <= stage k-1, for k=1..STAGES-1
- Stall (Stall=1):
  - all stages hold valid, ctrl and data.
  - In_* are ignored; upstream must hold its inputs.
- Flush:
  - Applied after the advance/hold selection, for the value landing in stage k.
  - If Flush[k]=1, stage k valid <= 0 and ctrl <= 0; data is still written (advance) or held (stall).
  - Flush overrides Stall for the masked stages only.
- Bubble rule: ctrl of any stage whose valid is 0 is always 0. In_Ctrl is masked to 0 when In_Valid=0, so no memory enable/write/regfile write can leak from a bubble.
- Outputs: Out_* are direct register outputs of stage STAGES-1, with no combinational path from inputs.
- Occupancy: registered population count of the next-state valid bits; it is consistent with the stage contents in the same cycle.
- Simultaneous events:
  - Stall+Flush on the same stage: flush wins.
  - All Flush bits set with Stall=0: the new entry is also killed, and Occupancy=0 next cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Stall_Cycles increments on every edge with Stall=1 and CLR=0.
  - Flush_Events increments on every edge where Flush destroys at least one valid entry, meaning the pre-flush valid bit landing in a masked stage was 1.
  - Both counters saturate at 16'hFFFF and clear on CLR.
- Undefined: both counters are tied to 16'h0000 and no counter logic is synthesised. Ports remain for interface stability.

Test Plan:
- Reset: CLR=1 for 2 cycles with In_Valid=1, In_Ctrl=5'h1F, In_Data=32'hDEADBEEF -> all outputs 0, Occupancy=0.
- Latency (STAGES=3): inject valid entries A (ctrl 5'h11, data 32'h1), B and C on consecutive cycles with no stall -> A on outputs at the 3rd edge, then B, then C; Occupancy rises 1,2,3.
- Bubble masking: In_Valid=0, In_Ctrl=5'h1F -> that entry exits with Out_Valid=0 and Out_Ctrl=5'h00, and Out_Data equals the injected data.
- Stall (STAGES=3, full): Stall=1 for 4 cycles -> outputs and Occupancy=3 frozen; with PIPE_PERF_CNT_EN, Stall_Cycles=4.
- Flush under stall: Stall=1, Flush=3'b010 with stage1 valid -> stage1 valid=0 and ctrl=0 next cycle, stages 0 and 2 unchanged, Occupancy drops by 1, Flush_Events=1.
- Full flush with advance: Flush=3'b111, Stall=0, In_Valid=1 -> Occupancy=0 and Out_Valid=0 next cycle. CLR asserted mid-sequence -> everything 0 the next cycle.
